ifetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control unit `cu`. It owns the program counter, drives the synchronous instruction memory, and latches returned words into the instruction register (`ir`, feeding `cu.ir`) or the operand register (`opr`, immediate/jump target). It executes the `imem_read`, `pc_inc` and `jump` strobes issued by `cu`, and resolves JUMPNZ against the ALU zero flag.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/pc_reg.sv | 30 +++
 rtl/ifetch_unit.sv | 109 ++++++++++
 tb/tb_ifetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map and fetch destination-select state
// encoding. Imported by the fetch stage and by the control unit.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LOAD   = 4'h1,
        OP_LOADIM = 4'h2,
        OP_STORE  = 4'h3,
        OP_ADD    = 4'h4,
        OP_SUB    = 4'h5,
        OP_AND    = 4'h6,
        OP_OR     = 4'h7,
        OP_XOR    = 4'h8,
        OP_NOT    = 4'h9,
        OP_JUMP   = 4'hA,
        OP_JUMPNZ = 4'hB,
        OP_SHL    = 4'hC,
        OP_SHR    = 4'hD,
        OP_CMP    = 4'hE,
        OP_END    = 4'hF
    } opcode_e;

    // Where the next returned memory word is written.
    typedef enum logic {
        SEL_IR  = 1'b0,
        SEL_OPR = 1'b1
    } dst_sel_e;

    // Opcodes whose instruction word is followed by an operand word.
    function automatic logic needs_operand(input logic [3:0] op);
        return (op == OP_LOADIM) || (op == OP_JUMPNZ);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk, reset : clock, synchronous active-high reset (pc -> 0)
//   hold       : freeze pc (highest priority after reset)
//   load       : load load_val
//   inc        : pc + 1, wrapping modulo 2^PC_W
//   pc         : current program counter
module pc_reg #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (reset)
            pc <= '0;
        else if (hold)
            pc <= pc;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + PC_W'(1);
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage. Owns the PC, drives a synchronous instruction
// memory (1-cycle read latency) and steers returned words into ir or opr.
//   clk, reset            : clock, synchronous active-high reset
//   imem_read, pc_inc     : fetch / advance strobes from cu
//   jump, alu_zero        : JUMPNZ qualifier and ALU zero flag
//   imem_rdata            : memory read data (cycle after imem_en)
//   imem_en, imem_addr    : memory read enable / address (combinational)
//   pc, ir, opr           : program counter, instruction, operand registers
//   ir_valid, opr_valid   : register contents valid
//   halted                : END opcode latched into ir
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH  = 16,
    parameter int OPCODE_LEN = 4,
    parameter int PC_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_read,
    input  logic                 pc_inc,
    input  logic                 jump,
    input  logic                 alu_zero,
    input  logic [BUS_WIDTH-1:0] imem_rdata,
    output logic                 imem_en,
    output logic [PC_W-1:0]      imem_addr,
    output logic [PC_W-1:0]      pc,
    output logic [BUS_WIDTH-1:0] ir,
    output logic [BUS_WIDTH-1:0] opr,
    output logic                 ir_valid,
    output logic                 opr_valid,
    output logic                 halted
);

    dst_sel_e                state, state_nxt;
    dst_sel_e                rd_dst;
    logic                    rd_pend;
    logic                    wr_ir, wr_opr;
    logic [OPCODE_LEN-1:0]   land_op;

    assign imem_en   = imem_read & ~halted;
    assign imem_addr = pc;
    assign land_op   = imem_rdata[BUS_WIDTH-1 -: OPCODE_LEN];

    // A taken JUMPNZ loads the operand; halted freezes the PC entirely.
    pc_reg #(.PC_W(PC_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .hold     (halted),
        .load     (pc_inc & jump & ~alu_zero),
        .load_val (opr[PC_W-1:0]),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // Destination FSM: state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= SEL_IR;
        else
            state <= state_nxt;
    end

    // Next state follows the landed word. The destination is the one captured
    // at issue time, so back-to-back reads keep their original routing.
    always_comb begin
        state_nxt = state;
        if (rd_pend) begin
            if (rd_dst == SEL_IR)
                state_nxt = needs_operand(land_op) ? SEL_OPR : SEL_IR;
            else
                state_nxt = SEL_IR;
        end
    end

    // Write strobes for the landing word
    always_comb begin
        wr_ir  = rd_pend && (rd_dst == SEL_IR);
        wr_opr = rd_pend && (rd_dst == SEL_OPR);
    end

    // Read tracking and destination registers. Reset drops an in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend   <= 1'b0;
            rd_dst    <= SEL_IR;
            ir        <= '0;
            opr       <= '0;
            ir_valid  <= 1'b0;
            opr_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            rd_pend <= imem_en;
            rd_dst  <= state;
            if (wr_ir) begin
                ir        <= imem_rdata;
                ir_valid  <= 1'b1;
                opr_valid <= 1'b0;
                if (land_op == OP_END)
                    halted <= 1'b1;
            end
            if (wr_opr) begin
                opr       <= imem_rdata;
                opr_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a cycle-level reference model pushes
// expected outputs into queues; monitors pop and compare against the DUT.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_read = 1'b0, pc_inc = 1'b0, jump = 1'b0, alu_zero = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        imem_en;
    logic [7:0]  imem_addr, pc;
    logic [15:0] ir, opr;
    logic        ir_valid, opr_valid, halted;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .imem_read  (imem_read),
        .pc_inc     (pc_inc),
        .jump       (jump),
        .alu_zero   (alu_zero),
        .imem_rdata (imem_rdata),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .ir         (ir),
        .opr        (opr),
        .ir_valid   (ir_valid),
        .opr_valid  (opr_valid),
        .halted     (halted)
    );

    // Synchronous instruction memory
    logic [15:0] mem [256];
    always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir, opr;
        logic        irv, oprv, halt;
    } reg_exp_t;
    typedef struct {
        logic       en;
        logic [7:0] addr;
    } comb_exp_t;

    reg_exp_t  reg_q[$];
    comb_exp_t comb_q[$];

    // Reference model state
    logic [7:0]  m_pc = 0;
    logic [15:0] m_ir = 0, m_opr = 0;
    logic        m_irv = 0, m_oprv = 0, m_halt = 0;
    bit          m_want_opr = 0;          // next fetched word is an operand
    bit          pend_dst[$];
    logic [15:0] pend_word[$];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the matching model step.
    task automatic cyc(input bit rd, input bit inc, input bit jmp, input bit z, input bit rst);
        comb_exp_t   ce;
        reg_exp_t    re;
        logic [7:0]  npc;
        logic [15:0] old_opr, w;
        bit          old_want, old_halt, d;
        @(negedge clk);
        reset = rst; imem_read = rd; pc_inc = inc; jump = jmp; alu_zero = z;
        ce.en   = rd & ~m_halt;
        ce.addr = m_pc;
        comb_q.push_back(ce);
        if (rst) begin
            m_pc = 0; m_ir = 0; m_opr = 0; m_irv = 0; m_oprv = 0; m_halt = 0;
            m_want_opr = 0;
            pend_dst.delete(); pend_word.delete();
        end else begin
            npc = m_pc; old_opr = m_opr; old_want = m_want_opr; old_halt = m_halt;
            if (pend_word.size() > 0) begin
                w = pend_word.pop_front();
                d = pend_dst.pop_front();
                if (!d) begin
                    m_ir = w; m_irv = 1; m_oprv = 0;
                    if (w[15:12] == 4'hF) m_halt = 1;
                    m_want_opr = (w[15:12] == 4'h2) || (w[15:12] == 4'hB);
                end else begin
                    m_opr = w; m_oprv = 1; m_want_opr = 0;
                end
            end
            if (!old_halt) begin
                if (inc && jmp && !z) npc = old_opr[7:0];
                else if (inc)         npc = m_pc + 8'd1;
            end
            if (rd && !old_halt) begin
                pend_dst.push_back(old_want);
                pend_word.push_back(mem[m_pc]);
            end
            m_pc = npc;
        end
        re.pc = m_pc; re.ir = m_ir; re.opr = m_opr;
        re.irv = m_irv; re.oprv = m_oprv; re.halt = m_halt;
        reg_q.push_back(re);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
    endtask

    // Registered-output monitor
    initial forever begin
        reg_exp_t e;
        @(posedge clk); #1;
        if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            chk("pc", pc, e.pc);
            chk("ir", ir, e.ir);
            chk("opr", opr, e.opr);
            chk("ir_valid", ir_valid, e.irv);
            chk("opr_valid", opr_valid, e.oprv);
            chk("halted", halted, e.halt);
        end
    end

    // Combinational memory-interface monitor
    initial forever begin
        comb_exp_t e;
        @(negedge clk); #2;
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            chk("imem_en", imem_en, e.en);
            if (e.en) chk("imem_addr", imem_addr, e.addr);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Reset state
        do_reset();
        cyc(0, 0, 0, 0, 0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);

        // Single fetch
        do_reset();
        mem[0] = 16'h7123;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("fetch_ir", ir, 16'h7123);
        chk("fetch_ir_valid", ir_valid, 1'b1);
        chk("fetch_pc", pc, 8'h01);
        chk("fetch_opr_valid", opr_valid, 1'b0);

        // LOADIM followed by operand, then an ordinary fetch goes to ir
        do_reset();
        mem[0] = 16'h2A00; mem[1] = 16'h00FF; mem[2] = 16'h4321;
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("loadim_ir", ir, 16'h2A00);
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("loadim_opr", opr, 16'h00FF);
        chk("loadim_opr_valid", opr_valid, 1'b1);
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("loadim_back_to_ir", ir, 16'h4321);

        // JUMPNZ taken / not taken / jump alone
        do_reset();
        mem[0] = 16'hB000; mem[1] = 16'h0040;
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("jnz_taken_pc", pc, 8'h40);
        cyc(0, 1, 1, 1, 0); cyc(0, 0, 0, 0, 0);
        chk("jnz_not_taken_pc", pc, 8'h41);
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("jump_alone_pc", pc, 8'h41);

        // PC wrap with simultaneous read + inc at 0xFF
        do_reset();
        mem[0] = 16'hB000; mem[1] = 16'h00FF; mem[255] = 16'h1234;
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("wrap_addr", imem_addr, 8'hFF);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("wrap_ir", ir, 16'h1234);
        chk("wrap_pc", pc, 8'h00);

        // Halt
        do_reset();
        mem[0] = 16'hF000;
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("halt_set", halted, 1'b1);
        cyc(1, 1, 0, 0, 0);
        chk("halt_en_low", imem_en, 1'b0);
        cyc(1, 1, 1, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("halt_pc_frozen", pc, 8'h01);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
        chk("halt_cleared", halted, 1'b0);
        chk("halt_rst_pc", pc, 8'h00);

        // Reset mid-read while the FSM expects an operand
        do_reset();
        mem[0] = 16'h2000; mem[1] = 16'h9999;
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("midrd_ir", ir, 16'h0000);
        chk("midrd_ir_valid", ir_valid, 1'b0);
        chk("midrd_opr", opr, 16'h0000);
        mem[0] = 16'h5555;
        cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("midrd_sel_ir", ir, 16'h5555);

        // Randomized traffic, END opcodes kept rare
        do_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i][15:12] == 4'hF && $urandom_range(3) != 0) mem[i][15:12] = 4'h1;
        end
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(1), $urandom_range(1), $urandom_range(2) == 0,
                $urandom_range(1), $urandom_range(79) == 0);

        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        @(posedge clk); #3;
        chk("sb_drain", reg_q.size() + comb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
